// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle CPU control unit with its own state register.
// Decodes the IR opcode, sequences FETCH..EXEC_ZI, waits on mem_ready in memory
// states, freezes under pause, traps illegal opcodes, runs a memory watchdog and
// counts retired instructions.
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   pause               freeze state/counters, force enables low
//   opcode              instr[31:26] from IR
//   mem_ready           memory completes the current access
//   PCWrite..ALUwrite   1-bit datapath controls
//   PCSource, ALUop, ALUsrcB, ALUsrcA   2-bit mux selects
//   state               current state (debug)
//   illegal_op          1-cycle pulse on undefined opcode trap
//   mem_timeout         1-cycle pulse on watchdog expiry
//   retired_cnt         retired instruction counter (wraps)
module mc_control_fsm #(
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             lorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             Extensrc,
  output logic             ALUwrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUop,
  output logic [1:0]       ALUsrcB,
  output logic [1:0]       ALUsrcA,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_I_WB     = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_EXEC_ZI  = 4'd12;

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(6'b001100);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(6'b001101);
  localparam logic [OPC_W-1:0] OP_LUI  = OPC_W'(6'b001111);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [3:0]        next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              trap;
  logic              timeout;
  logic              retire;
  logic              en;

  function automatic logic is_mem(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // Next state, trap/timeout/retire events; nothing advances while paused.
  always_comb begin
    next_state = state;
    trap       = 1'b0;
    timeout    = 1'b0;
    retire     = 1'b0;
    if (!pause) begin
      if ((TIMEOUT != 0) && is_mem(state) && !mem_ready && (wait_cnt == WAIT_LAST)) begin
        timeout    = 1'b1;
        next_state = S_FETCH;
      end else begin
        case (state)
          S_FETCH:    if (mem_ready) next_state = S_DECODE;
          S_DECODE: begin
            case (opcode)
              OP_LW, OP_SW, OP_ADDI: next_state = S_MEM_ADDR;
              OP_R:                  next_state = S_EXEC_R;
              OP_BEQ:                next_state = S_BRANCH;
              OP_J:                  next_state = S_JUMP;
              OP_LUI:                next_state = S_LUI;
              OP_ANDI, OP_ORI:       next_state = S_EXEC_ZI;
              default: begin
                next_state = S_FETCH;
                trap       = 1'b1;
              end
            endcase
          end
          // IR still holds the opcode, so MEM_ADDR re-dispatches on it
          S_MEM_ADDR: begin
            case (opcode)
              OP_LW:   next_state = S_MEM_RD;
              OP_SW:   next_state = S_MEM_WR;
              OP_ADDI: next_state = S_I_WB;
              default: next_state = S_FETCH;
            endcase
          end
          S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
          S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
          S_EXEC_R:   next_state = S_R_WB;
          S_LUI,
          S_EXEC_ZI:  next_state = S_I_WB;
          default:    next_state = S_FETCH;
        endcase
      end
      retire = !timeout && (next_state == S_FETCH) &&
               ((state == S_MEM_WB) || (state == S_MEM_WR) || (state == S_R_WB) ||
                (state == S_BRANCH) || (state == S_JUMP)   || (state == S_I_WB));
    end
  end

  // State, watchdog, counter and event pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      retired_cnt <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      illegal_op  <= trap;
      mem_timeout <= timeout;
      if (!pause) begin
        state <= next_state;
        if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
        if (timeout || mem_ready || ((next_state != state) && is_mem(next_state)))
          wait_cnt <= '0;
        else if ((TIMEOUT != 0) && is_mem(state))
          wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Moore decode; enables are qualified by pause and by reset.
  always_comb begin
    en          = !pause && !rst;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    lorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    Extensrc    = 1'b0;
    ALUwrite    = 1'b0;
    PCSource    = 2'd0;
    ALUop       = 2'd0;
    ALUsrcB     = 2'd0;
    ALUsrcA     = 2'd0;
    case (state)
      S_FETCH: begin
        PCWrite = en && mem_ready;
        IRWrite = en && mem_ready;
        MemRead = en;
        ALUsrcB = 2'd1;
      end
      S_DECODE: begin
        ALUwrite = en;
        ALUsrcB  = 2'd2;
      end
      S_MEM_ADDR: begin
        ALUwrite = en;
        ALUsrcA  = 2'd1;
        ALUsrcB  = 2'd2;
      end
      S_MEM_RD: begin
        lorD    = 1'b1;
        MemRead = en;
      end
      S_MEM_WB: begin
        MemToReg = 1'b1;
        RegWrite = en;
      end
      S_MEM_WR: begin
        lorD     = 1'b1;
        MemWrite = en;
      end
      S_EXEC_R: begin
        ALUwrite = en;
        ALUsrcA  = 2'd1;
        ALUop    = 2'd2;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = en;
      end
      S_BRANCH: begin
        PCWriteCond = en;
        ALUsrcA     = 2'd1;
        ALUop       = 2'd1;
        PCSource    = 2'd1;
      end
      S_JUMP: begin
        PCWrite  = en;
        PCSource = 2'd2;
      end
      S_I_WB: RegWrite = en;
      S_LUI: begin
        ALUwrite = en;
        ALUsrcA  = 2'd2;
        ALUsrcB  = 2'd3;
      end
      S_EXEC_ZI: begin
        Extensrc = 1'b1;
        ALUwrite = en;
        ALUsrcA  = 2'd1;
        ALUsrcB  = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm (CNT_W=4, TIMEOUT=4).
// The reference model walks per-opcode state paths and derives outputs from
// per-state tables; directed scenarios plus a randomized run are compared to it.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam int TMO = 4;

  logic clk, rst, pause, mem_ready;
  logic [5:0] opcode;
  logic PCWrite, PCWriteCond, lorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite;
  logic RegDst, Extensrc, ALUwrite;
  logic [1:0] PCSource, ALUop, ALUsrcB, ALUsrcA;
  logic [3:0] state;
  logic illegal_op, mem_timeout;
  logic [3:0] retired_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mc_control_fsm #(.OPC_W(6), .CNT_W(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pause(pause), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .lorD(lorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .Extensrc(Extensrc), .ALUwrite(ALUwrite), .PCSource(PCSource),
    .ALUop(ALUop), .ALUsrcB(ALUsrcB), .ALUsrcA(ALUsrcA), .state(state),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [28:0] act = {PCWrite, PCWriteCond, lorD, MemRead, MemWrite, IRWrite, MemToReg,
                     RegWrite, RegDst, Extensrc, ALUwrite, PCSource, ALUop, ALUsrcB,
                     ALUsrcA, state, illegal_op, mem_timeout, retired_cnt};

  // Reference model: current state, the instruction's remaining path, counters.
  int   m_state, m_pos, m_len, m_wait, m_cnt;
  int   m_path[3];
  logic m_ill, m_to;

  task automatic m_reset();
    m_state = 0; m_pos = 0; m_len = 0; m_wait = 0; m_cnt = 0;
    m_ill = 1'b0; m_to = 1'b0;
  endtask

  task automatic set_path(input int a, input int b, input int c, input int len);
    m_path[0] = a; m_path[1] = b; m_path[2] = c; m_len = len;
  endtask

  // Advance the model by one clock using the bench-driven inputs.
  task automatic model_clk();
    if (rst) begin
      m_reset();
    end else begin
      m_ill = 1'b0;
      m_to  = 1'b0;
      if (!pause) begin
        if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
          m_wait++;
          if (m_wait == TMO) begin
            m_state = 0; m_wait = 0; m_to = 1'b1;
          end
        end else begin
          m_wait = 0;
          if (m_state == 0) begin
            m_state = 1;
          end else if (m_state == 1) begin
            case (opcode)
              OP_LW:           set_path(2, 3, 4, 3);
              OP_SW:           set_path(2, 5, 0, 2);
              OP_ADDI:         set_path(2, 10, 0, 2);
              OP_R:            set_path(6, 7, 0, 2);
              OP_BEQ:          set_path(8, 0, 0, 1);
              OP_J:            set_path(9, 0, 0, 1);
              OP_LUI:          set_path(11, 10, 0, 2);
              OP_ANDI, OP_ORI: set_path(12, 10, 0, 2);
              default:         set_path(0, 0, 0, 0);
            endcase
            m_pos = 0;
            if (m_len == 0) begin
              m_state = 0; m_ill = 1'b1;
            end else begin
              m_state = m_path[0];
            end
          end else begin
            m_pos++;
            if (m_pos >= m_len) begin
              m_state = 0; m_cnt = (m_cnt + 1) % 16;
            end else begin
              m_state = m_path[m_pos];
            end
          end
        end
      end
    end
  endtask

  // Expected output vector from the control table for the model state.
  function automatic logic [28:0] exp_vec();
    logic en;
    int s;
    logic [1:0] pcs, aop, sb, sa;
    en  = !pause && !rst;
    s   = m_state;
    sa  = (s == 2 || s == 6 || s == 8 || s == 12) ? 2'd1 : (s == 11) ? 2'd2 : 2'd0;
    sb  = (s == 0) ? 2'd1 : (s == 1 || s == 2 || s == 12) ? 2'd2 : (s == 11) ? 2'd3 : 2'd0;
    aop = (s == 6) ? 2'd2 : (s == 8) ? 2'd1 : 2'd0;
    pcs = (s == 8) ? 2'd1 : (s == 9) ? 2'd2 : 2'd0;
    return {en && (s == 9 || (s == 0 && mem_ready)), en && s == 8, s == 3 || s == 5,
            en && (s == 0 || s == 3), en && s == 5, en && s == 0 && mem_ready, s == 4,
            en && (s == 4 || s == 7 || s == 10), s == 7, s == 12,
            en && (s == 1 || s == 2 || s == 6 || s == 11 || s == 12),
            pcs, aop, sb, sa, 4'(m_state), m_ill, m_to, 4'(m_cnt)};
  endfunction

  task automatic apply(input logic p, input logic mr, input logic [5:0] op);
    pause = p; mem_ready = mr; opcode = op;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  // Run the current instruction to completion with zero-wait memory.
  task automatic run_to_fetch(input logic [5:0] op);
    int guard;
    guard = 0;
    do begin
      apply(1'b0, 1'b1, op);
      tick();
      guard++;
    end while (m_state != 0 && guard < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_reset();
    apply(1'b0, 1'b1, OP_LW);
    n_checks++;
    if (act !== exp_vec()) begin
      n_errors++; $display("FAIL reset_vec: got %h expected %h", act, exp_vec());
    end
    n_checks++;
    if ({PCWrite, MemRead, IRWrite, ALUsrcB, state, retired_cnt} !== {3'b000, 2'd1, 4'd0, 4'd0}) begin
      n_errors++;
      $display("FAIL reset_state: got %b expected %b",
               {PCWrite, MemRead, IRWrite, ALUsrcB, state, retired_cnt}, {3'b000, 2'd1, 8'd0});
    end
    tick();
    rst = 1'b0;
    apply(1'b0, 1'b0, OP_LW);
    n_checks++;
    if (MemRead !== 1'b1) begin
      n_errors++; $display("FAIL reset_release_memread: got %b expected 1", MemRead);
    end
  endtask

  task automatic test_lw();
    int exp_s[5];
    exp_s = '{0, 1, 2, 3, 4};
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, OP_LW);
      n_checks++;
      if (act !== exp_vec()) begin
        n_errors++; $display("FAIL lw_vec[%0d]: got %h expected %h", i, act, exp_vec());
      end
      n_checks++;
      if ({state, RegWrite && MemToReg} !== {4'(exp_s[i]), i == 4}) begin
        n_errors++;
        $display("FAIL lw_seq[%0d]: got state %0d wb %b expected state %0d wb %b",
                 i, state, RegWrite && MemToReg, exp_s[i], i == 4);
      end
      tick();
    end
    n_checks++;
    if ({state, retired_cnt} !== {4'd0, 4'd1}) begin
      n_errors++; $display("FAIL lw_retire: got state %0d cnt %0d expected 0 1", state, retired_cnt);
    end
  endtask

  task automatic test_fetch_wait();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, i == 3, OP_R);
      n_checks++;
      if ({MemRead, IRWrite} !== {1'b1, i == 3} || act !== exp_vec()) begin
        n_errors++;
        $display("FAIL fetch_wait[%0d]: got %h expected %h", i, act, exp_vec());
      end
      tick();
    end
    n_checks++;
    if (state !== 4'd1) begin
      n_errors++; $display("FAIL fetch_wait_decode: got %0d expected 1", state);
    end
    run_to_fetch(OP_R);
  endtask

  task automatic test_pause();
    int c0;
    c0 = m_cnt;
    apply(1'b0, 1'b1, OP_R); tick();
    apply(1'b0, 1'b1, OP_R); tick();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, OP_R);
      n_checks++;
      if ({state, ALUwrite, ALUop} !== {4'd6, 1'b0, 2'd2} || act !== exp_vec()) begin
        n_errors++;
        $display("FAIL pause_hold[%0d]: got state %0d aluw %b aluop %0d expected 6 0 2",
                 i, state, ALUwrite, ALUop);
      end
      tick();
    end
    apply(1'b0, 1'b1, OP_R);
    tick();
    n_checks++;
    if (state !== 4'd7) begin
      n_errors++; $display("FAIL pause_resume: got %0d expected 7", state);
    end
    apply(1'b0, 1'b1, OP_R);
    tick();
    n_checks++;
    if ({state, retired_cnt} !== {4'd0, 4'(c0 + 1)}) begin
      n_errors++;
      $display("FAIL pause_retire: got state %0d cnt %0d expected 0 %0d", state, retired_cnt, (c0 + 1) % 16);
    end
  endtask

  task automatic test_timeout();
    int c0;
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, OP_SW); tick();
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, OP_SW);
      n_checks++;
      if ({state, MemWrite, mem_timeout} !== {4'd5, 1'b1, 1'b0} || act !== exp_vec()) begin
        n_errors++;
        $display("FAIL timeout_wait[%0d]: got state %0d memw %b to %b expected 5 1 0",
                 i, state, MemWrite, mem_timeout);
      end
      tick();
    end
    apply(1'b0, 1'b0, OP_SW);
    n_checks++;
    if ({state, mem_timeout, retired_cnt} !== {4'd0, 1'b1, 4'(c0)}) begin
      n_errors++;
      $display("FAIL timeout_fire: got state %0d to %b cnt %0d expected 0 1 %0d",
               state, mem_timeout, retired_cnt, c0);
    end
    tick();
    n_checks++;
    if (mem_timeout !== 1'b0) begin
      n_errors++; $display("FAIL timeout_pulse: got %b expected 0", mem_timeout);
    end
    run_to_fetch(OP_SW);
  endtask

  task automatic test_illegal();
    int c0;
    c0 = m_cnt;
    apply(1'b0, 1'b1, 6'h3f); tick();
    apply(1'b0, 1'b0, 6'h3f);
    n_checks++;
    if (state !== 4'd1) begin
      n_errors++; $display("FAIL illegal_decode: got %0d expected 1", state);
    end
    tick();
    n_checks++;
    if ({state, illegal_op, RegWrite, PCWrite, retired_cnt} !== {4'd0, 3'b100, 4'(c0)} ||
        act !== exp_vec()) begin
      n_errors++;
      $display("FAIL illegal_trap: got %h expected %h", act, exp_vec());
    end
    tick();
    n_checks++;
    if (illegal_op !== 1'b0) begin
      n_errors++; $display("FAIL illegal_pulse: got %b expected 0", illegal_op);
    end
  endtask

  task automatic test_wrap_and_reset();
    int c0;
    c0 = m_cnt;
    for (int i = 0; i < 17; i++) run_to_fetch(OP_R);
    apply(1'b0, 1'b1, OP_LUI);
    n_checks++;
    if (retired_cnt !== 4'(c0 + 17) || act !== exp_vec()) begin
      n_errors++; $display("FAIL wrap_cnt: got %0d expected %0d", retired_cnt, (c0 + 17) % 16);
    end
    tick();
    apply(1'b0, 1'b1, OP_LUI);
    tick();
    apply(1'b0, 1'b1, OP_LUI);
    n_checks++;
    if ({state, ALUwrite} !== {4'd11, 1'b1}) begin
      n_errors++; $display("FAIL lui_state: got %0d expected 11", state);
    end
    rst = 1'b1;
    m_reset();
    #1;
    n_checks++;
    if ({PCWrite, MemRead, IRWrite, RegWrite, ALUwrite, state, retired_cnt} !== 13'd0 ||
        act !== exp_vec()) begin
      n_errors++; $display("FAIL mid_lui_reset: got %h expected %h", act, exp_vec());
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops[9];
    logic [5:0] op;
    logic p, mr;
    ops = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
    op = OP_R;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0) begin
        if ($urandom_range(0, 7) == 0) op = 6'($urandom);
        else op = ops[$urandom_range(0, 8)];
      end
      rst = ($urandom_range(0, 299) == 0);
      if (rst) m_reset();
      p  = ($urandom_range(0, 3) == 0);
      mr = ($urandom_range(0, 9) < 6);
      apply(p, mr, op);
      n_checks++;
      if (act !== exp_vec()) begin
        n_errors++; $display("FAIL random[%0d]: got %h expected %h", i, act, exp_vec());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    m_reset();
    @(negedge clk);
    test_reset();
    test_lw();
    test_fetch_wait();
    test_pause();
    test_timeout();
    test_illegal();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
